// File: rtl/robo_limpa_tubos_ctrl.sv
// robo_limpa_tubos_ctrl: left-hand wall-following pipe-cleaning robot controller
// with timed trash removal, movement budget, drain halt and status counters.
// Optional stall detection is built when ROBO_STALL_DETECT_EN is defined.
module robo_limpa_tubos_ctrl #(
   parameter int REMOVE_CYCLES = 3,
   parameter int MOVE_W        = 9,
   parameter int MAX_MOVES     = 511,
   parameter bit HALT_ON_UNDER = 1'b1,
   parameter int STALL_TURNS   = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              head,
   input  logic              left,
   input  logic              under,
   input  logic              barrier,
   output logic              front,
   output logic              turn,
   output logic              remove,
   output logic              halted,
   output logic              stuck,
   output logic [MOVE_W-1:0] move_count,
   output logic [7:0]        removed_count
);
   localparam int RW = $clog2(REMOVE_CYCLES + 1);
   typedef enum logic [1:0] {RUN, REMOVE, HALT} state_t;
   state_t            state, state_d;
   logic [RW-1:0]     rem_cnt, rem_d;
   logic              last_turn, last_d;
   logic              front_d, turn_d, remove_d, halted_d, stuck_d;
   logic [MOVE_W-1:0] move_d, move_inc;
   logic [7:0]        removed_d, removed_inc;
   logic              want_turn;
`ifdef ROBO_STALL_DETECT_EN
   localparam int TW = $clog2(STALL_TURNS + 2);
   logic [TW-1:0]     turn_run, turn_run_d;
`endif
   assign move_inc    = (&move_count) ? move_count : move_count + 1'b1;
   assign removed_inc = (&removed_count) ? removed_count : removed_count + 8'd1;
   assign want_turn   = head || (!left && !last_turn);
   // Next-state and registered-output decision for one controller step
   always_comb begin
      state_d   = state;
      rem_d     = rem_cnt;
      last_d    = last_turn;
      front_d   = 1'b0;
      turn_d    = 1'b0;
      remove_d  = 1'b0;
      halted_d  = halted;
      stuck_d   = stuck;
      move_d    = move_count;
      removed_d = removed_count;
`ifdef ROBO_STALL_DETECT_EN
      turn_run_d = turn_run;
`endif
      if (enable) begin
         case (state)
            RUN: begin
               if (HALT_ON_UNDER && under) begin
                  state_d  = HALT;
                  halted_d = 1'b1;
               end else if (MAX_MOVES != 0 && 32'(move_count) == MAX_MOVES) begin
                  state_d  = HALT;
                  halted_d = 1'b1;
               end else if (!head && barrier) begin
                  state_d  = REMOVE;
                  remove_d = 1'b1;
                  rem_d    = RW'(1);
               end else if (want_turn) begin
`ifdef ROBO_STALL_DETECT_EN
                  if (32'(turn_run) == STALL_TURNS) begin
                     state_d  = HALT;
                     halted_d = 1'b1;
                     stuck_d  = 1'b1;
                  end else begin
                     turn_d     = 1'b1;
                     last_d     = 1'b1;
                     move_d     = move_inc;
                     turn_run_d = turn_run + 1'b1;
                  end
`else
                  turn_d = 1'b1;
                  last_d = 1'b1;
                  move_d = move_inc;
`endif
               end else begin
                  front_d = 1'b1;
                  last_d  = 1'b0;
                  move_d  = move_inc;
`ifdef ROBO_STALL_DETECT_EN
                  turn_run_d = '0;
`endif
               end
            end
            REMOVE: begin
               if (32'(rem_cnt) < REMOVE_CYCLES) begin
                  remove_d = 1'b1;
                  rem_d    = rem_cnt + 1'b1;
               end else begin
                  rem_d     = '0;
                  removed_d = removed_inc;
                  last_d    = 1'b0;
                  state_d   = RUN;
`ifdef ROBO_STALL_DETECT_EN
                  turn_run_d = '0;
`endif
               end
            end
            default: ;
         endcase
      end
   end
   // State, counters and registered outputs with asynchronous active-low reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= RUN;
         rem_cnt       <= '0;
         last_turn     <= 1'b0;
         front         <= 1'b0;
         turn          <= 1'b0;
         remove        <= 1'b0;
         halted        <= 1'b0;
         stuck         <= 1'b0;
         move_count    <= '0;
         removed_count <= '0;
      end else begin
         state         <= state_d;
         rem_cnt       <= rem_d;
         last_turn     <= last_d;
         front         <= front_d;
         turn          <= turn_d;
         remove        <= remove_d;
         halted        <= halted_d;
         stuck         <= stuck_d;
         move_count    <= move_d;
         removed_count <= removed_d;
      end
   end
`ifdef ROBO_STALL_DETECT_EN
   // Turns since the last forward move or completed removal
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) turn_run <= '0;
      else        turn_run <= turn_run_d;
   end
`endif
endmodule

// File: tb/tb_robo_limpa_tubos_ctrl.sv
// tb_robo_limpa_tubos_ctrl: randomized self-checking bench with a behavioural reference model.
module tb_robo_limpa_tubos_ctrl;
   localparam int RC  = 3;
   localparam int MW  = 9;
   localparam int MAX = 60;
   localparam bit HOU = 1'b1;
   localparam int ST  = 4;
`ifdef ROBO_STALL_DETECT_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif
   logic clock = 1'b0, reset = 1'b0, enable = 1'b1;
   logic head = 1'b0, left = 1'b1, under = 1'b0, barrier = 1'b0;
   logic front, turn, remove, halted, stuck;
   logic [MW-1:0] move_count;
   logic [7:0] removed_count;
   logic [MW+12:0] dut_vec;
   int tests = 0, fails = 0;
   // model state: 0 run, 1 removing, 2 halted
   int m_state, m_rem, m_moves, m_removed, m_turns;
   bit m_last, m_front, m_turn, m_remove, m_halted, m_stuck;

   robo_limpa_tubos_ctrl #(.REMOVE_CYCLES(RC), .MOVE_W(MW), .MAX_MOVES(MAX),
                           .HALT_ON_UNDER(HOU), .STALL_TURNS(ST)) dut (
      .clock(clock), .reset(reset), .enable(enable), .head(head), .left(left),
      .under(under), .barrier(barrier), .front(front), .turn(turn), .remove(remove),
      .halted(halted), .stuck(stuck), .move_count(move_count), .removed_count(removed_count));

   always #5 clock = ~clock;
   assign dut_vec = {front, turn, remove, halted, stuck, move_count, removed_count};

   function automatic logic [MW+12:0] exp_vec();
      return {m_front, m_turn, m_remove, m_halted, m_stuck, MW'(m_moves), 8'(m_removed)};
   endfunction

   task automatic model_reset();
      m_state = 0; m_rem = 0; m_moves = 0; m_removed = 0; m_turns = 0;
      m_last = 0; m_front = 0; m_turn = 0; m_remove = 0; m_halted = 0; m_stuck = 0;
   endtask

   task automatic bump_moves();
      if (m_moves < (1 << MW) - 1) m_moves++;
   endtask

   task automatic model_step();
      m_front = 0; m_turn = 0; m_remove = 0;
      if (!enable || m_state == 2) return;
      if (m_state == 1) begin
         if (m_rem < RC) begin m_remove = 1; m_rem++; end
         else begin
            m_rem = 0; m_turns = 0; m_last = 0; m_state = 0;
            if (m_removed < 255) m_removed++;
         end
         return;
      end
      if ((HOU && under) || (MAX != 0 && m_moves == MAX)) begin
         m_state = 2; m_halted = 1;
      end else if (!head && barrier) begin
         m_state = 1; m_remove = 1; m_rem = 1;
      end else if (head || (!left && !m_last)) begin
         if (STALL_EN && m_turns == ST) begin
            m_state = 2; m_halted = 1; m_stuck = 1;
         end else begin
            m_turn = 1; m_last = 1; m_turns++; bump_moves();
         end
      end else begin
         m_front = 1; m_last = 0; m_turns = 0; bump_moves();
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; enable = 1'b1; head = 1'b0; left = 1'b1; under = 1'b0; barrier = 1'b0;
      model_reset();
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      head = 1'($urandom); left = 1'($urandom); barrier = 1'($urandom);
      repeat (3) @(posedge clock);
      #2;
      tests++;
      if (dut_vec !== '0) begin fails++; $display("FAIL reset_state: got %h exp 0", dut_vec); end
      do_reset();
   endtask

   task automatic test_corridor();
      do_reset();
      head = 0; left = 1; barrier = 0;
      tick();
      tests++;
      if (front !== 1'b1 || dut_vec !== exp_vec()) begin
         fails++; $display("FAIL corridor_first: got %h exp %h", dut_vec, exp_vec());
      end
      tick(); tick();
      tests++;
      if (move_count !== MW'(3)) begin
         fails++; $display("FAIL corridor_count: got %0d exp 3", move_count);
      end
   endtask

   task automatic test_lost_left();
      do_reset();
      head = 0; left = 0; barrier = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         tests++;
         if (turn !== 1'(i % 2 == 0) || front !== 1'(i % 2 == 1) ||
             move_count !== MW'(i + 1) || dut_vec !== exp_vec()) begin
            fails++; $display("FAIL lost_left[%0d]: got %h exp %h", i, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_barrier();
      int highs;
      do_reset();
      head = 0; left = 1; barrier = 1;
      tick();
      highs = remove ? 1 : 0;
      for (int i = 0; i < 4; i++) begin
         head = 1'($urandom); left = 1'($urandom); barrier = 1'($urandom);
         tick();
         if (remove) highs++;
         tests++;
         if (dut_vec !== exp_vec()) begin
            fails++; $display("FAIL barrier_cycle[%0d]: got %h exp %h", i, dut_vec, exp_vec());
         end
         if (i == 1) begin head = 1; left = 1; end
      end
      tests++;
      if (highs !== RC || removed_count !== 8'd1 || move_count !== MW'(1)) begin
         fails++;
         $display("FAIL barrier_summary: got highs=%0d removed=%0d moves=%0d exp highs=%0d removed=1 moves=1",
                  highs, removed_count, move_count, RC);
      end
   endtask

   task automatic test_removed_saturation();
      do_reset();
      head = 0; left = 1; barrier = 1;
      for (int i = 0; i < 270 * (RC + 1); i++) tick();
      tests++;
      if (removed_count !== 8'd255 || move_count !== '0 || dut_vec !== exp_vec()) begin
         fails++; $display("FAIL removed_sat: got %h exp %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_budget();
      int fronts, cyc;
      do_reset();
      head = 0; left = 1; barrier = 0;
      fronts = 0; cyc = 0;
      while (!halted && cyc < 200) begin
         tick(); cyc++;
         if (front) fronts++;
      end
      tests++;
      if (fronts !== MAX || halted !== 1'b1 || stuck !== 1'b0 || front !== 1'b0) begin
         fails++; $display("FAIL budget: got fronts=%0d halted=%b stuck=%b exp fronts=%0d halted=1 stuck=0",
                           fronts, halted, stuck, MAX);
      end
      for (int i = 0; i < 20; i++) begin
         head = 1'($urandom); left = 1'($urandom); barrier = 1'($urandom); under = 1'($urandom);
         tick();
         tests++;
         if (dut_vec !== exp_vec() || {front, turn, remove} !== 3'b000) begin
            fails++; $display("FAIL budget_hold[%0d]: got %h exp %h", i, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_stall();
      int turns, cyc;
      do_reset();
      head = 1; left = 1; barrier = 0;
      turns = 0; cyc = 0;
      while (!halted && cyc < 200) begin
         tick(); cyc++;
         if (turn) turns++;
      end
      tests++;
      if (turns !== (STALL_EN ? ST : MAX) || halted !== 1'b1 || stuck !== STALL_EN || turn !== 1'b0) begin
         fails++; $display("FAIL stall: got turns=%0d halted=%b stuck=%b exp turns=%0d halted=1 stuck=%b",
                           turns, halted, stuck, STALL_EN ? ST : MAX, STALL_EN);
      end
   endtask

   task automatic test_drain();
      do_reset();
      head = 0; left = 1; barrier = 1'b0;
      tick(); tick();
      under = 1; barrier = 1;
      tick();
      tests++;
      if (halted !== 1'b1 || {front, turn, remove} !== 3'b000 || move_count !== MW'(2)) begin
         fails++; $display("FAIL drain: got %h exp halted=1 no action moves=2", dut_vec);
      end
   endtask

   task automatic test_reset_mid_remove();
      do_reset();
      head = 0; left = 1; barrier = 1;
      tick(); tick();
      #2 reset = 1'b0;
      #1;
      tests++;
      if (remove !== 1'b0 || removed_count !== 8'd0) begin
         fails++; $display("FAIL reset_mid_remove: got remove=%b removed=%0d exp 0 0", remove, removed_count);
      end
      model_reset();
      @(negedge clock);
      reset = 1'b1; head = 1; barrier = 0;
      tick();
      tests++;
      if (removed_count !== 8'd0 || turn !== 1'b1 || dut_vec !== exp_vec()) begin
         fails++; $display("FAIL reset_release: got %h exp %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_enable_freeze();
      int highs;
      do_reset();
      head = 0; left = 1; barrier = 1;
      tick();
      highs = remove ? 1 : 0;
      enable = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (dut_vec !== exp_vec() || remove !== 1'b0) begin
            fails++; $display("FAIL freeze[%0d]: got %h exp %h", i, dut_vec, exp_vec());
         end
      end
      enable = 1;
      for (int i = 0; i < RC; i++) begin
         tick();
         if (remove) highs++;
      end
      tests++;
      if (highs !== RC || removed_count !== 8'd1 || dut_vec !== exp_vec()) begin
         fails++; $display("FAIL freeze_resume: got highs=%0d vec=%h exp highs=%0d vec=%h",
                           highs, dut_vec, RC, exp_vec());
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         head    = ($urandom_range(0, 99) < 35);
         left    = ($urandom_range(0, 99) < 60);
         barrier = ($urandom_range(0, 99) < 20);
         under   = ($urandom_range(0, 99) < 2);
         enable  = ($urandom_range(0, 99) < 90);
         tick();
         tests++;
         if (dut_vec !== exp_vec()) begin
            fails++; $display("FAIL random[%0d]: got %h exp %h", i, dut_vec, exp_vec());
         end
         if (m_state == 2 && $urandom_range(0, 3) == 0) do_reset();
      end
   endtask

   initial begin
      test_reset();
      test_corridor();
      test_lost_left();
      test_barrier();
      test_removed_saturation();
      test_budget();
      test_stall();
      test_drain();
      test_reset_mid_remove();
      test_enable_freeze();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/robo_limpa_tubos_ctrl.md
# robo_limpa_tubos_ctrl

Parametrised second-generation pipe-cleaning robot controller. It implements the left-hand wall-following policy from the head, left, under and barrier sensors, and issues one action per cycle: front, turn (left 90°) or remove. Compared with the first-generation controller it adds:
- a configurable trash-removal duration;
- a movement budget;
- a drain-halt mode;
- stall detection;
- status counters.

It sits between the sensor model or testbench map and the robot position tracker.

## Interface
Parameters:
- REMOVE_CYCLES, 3, consecutive cycles remove is held per barrier (≥1)
- MOVE_W, 9, width of move_count
- MAX_MOVES, 511, action budget; 0 = unlimited
- HALT_ON_UNDER, 1, 1 = halt when under=1
- STALL_TURNS, 4, consecutive turns allowed before stuck (used only with ROBO_STALL_DETECT_EN)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  1 = controller advances; 0 = freeze
- head  in  1  wall directly ahead
- left  in  1  wall on robot's left
- under  in  1  drain/exit cell beneath robot
- barrier  in  1  removable trash directly ahead
- front  out  1  move one cell forward
- turn  out  1  rotate 90° left in place
- remove  out  1  removal action on the cell ahead
- halted  out  1  controller stopped until reset
- stuck  out  1  halt caused by stall detection
- move_count  out  MOVE_W  registered front+turn actions, saturating
- removed_count  out  8  completed removals, saturating at 255

## Operation
- States: RUN, REMOVE, HALT.
- Internal registers:
  - last_turn flag;
  - turn_run counter (turns since last front/removal);
  - rem_cnt.
- All outputs are registered. At most one of front/turn/remove is high at any time.

RUN decision at each rising edge with enable=1, in priority order:
1. HALT_ON_UNDER=1 and under=1 → HALT.
2. MAX_MOVES≠0 and move_count==MAX_MOVES → HALT.
3. head=0 and barrier=1 → REMOVE: remove=1, rem_cnt=1.
4. left=0 and last_turn=0 → turn; last_turn=1.
5. head=0 → front; last_turn=0, turn_run=0.
6. Otherwise → turn; last_turn=1.

Rules applied to the decision:
- head=1 overrides barrier; the cell is treated as wall.
- Every registered turn increments turn_run and move_count. Every front increments move_count.

REMOVE:
- Sensors are ignored.
- At each edge, if rem_cnt<REMOVE_CYCLES: remove stays 1 and rem_cnt is incremented.
- Otherwise: remove=0, removed_count is incremented, turn_run=0, last_turn=0, and the state returns to RUN with no action for that cycle.

HALT:
- All actions are 0 and halted=1.
- Exit only via reset.

enable=0:
- Actions are forced to 0.
- State, counters and rem_cnt are held. Removal pauses and resumes without restart.

## Timing
- Reset (async, reset=0): all outputs 0, state RUN, all internal counters 0, flags cleared.
- Latency: sensors sampled at edge N drive the action valid from edge N until edge N+1.
- remove is high for exactly REMOVE_CYCLES cycles, followed by one idle cycle.
- Halt at edge N: the action is 0 from edge N onward. halted=1 from edge N.
- Simultaneous halt causes use the precedence under > budget > stall. stuck=1 only when stall is the cause.
- Reset asserted mid-removal: remove drops immediately and removed_count does not increment.
- move_count and removed_count saturate and never wrap.

## Configuration
- ROBO_STALL_DETECT_EN defined:
  - At a RUN edge where the decision is turn and turn_run==STALL_TURNS, the controller goes to HALT with stuck=1 and no turn is issued.
  - The robot therefore performs at most STALL_TURNS consecutive turns.
- ROBO_STALL_DETECT_EN undefined:
  - No stall logic is built and stuck is tied 0.
  - Turning continues indefinitely, subject to the budget.

## Test plan
- Reset, then open corridor: hold reset=0 → all outputs 0. Release with head=0, left=1, barrier=0 → front=1 after the first edge; move_count=3 after 3 edges.
- Lost left wall: left=0, head=0 held → turn for 1 cycle, then front (no second turn), then turn again; move_count increments each cycle.
- Barrier, REMOVE_CYCLES=3: head=0, barrier=1 → remove=1 for 3 cycles regardless of sensor toggling, then 1 idle cycle; removed_count=1; move_count unchanged.
- Budget, MAX_MOVES=5: open corridor → 5 front cycles, then halted=1, front=0, stuck=0; outputs stay 0 for 20 further cycles.
- Stall: head=1, left=1 constant.
  - With ROBO_STALL_DETECT_EN and STALL_TURNS=4 → 4 turns, then halted=1, stuck=1.
  - Without the macro → turns continue until the budget halts with stuck=0.
- Drain and async reset:
  - under=1 with HALT_ON_UNDER=1 → halted=1 at the next edge with no action.
  - Separately, reset pulsed low on the 2nd remove cycle → remove=0 immediately; removed_count=0 after release.
